// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the req/gnt/rvalid SRAM responder.
package mem_resp_pkg;
    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        BUSY,
        RESP
    } state_e;
endpackage

// File: rtl/sram_1rw_be.sv
// Single-port DEPTH x 32 array with byte write mask and registered read.
module sram_1rw_be
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) rdata_d = mem[addr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_resp_sram.sv
// SRAM-backed target for the data-memory req/gnt/rvalid protocol.
// Define MEM_RESP_ERR_EN to flag out-of-range addresses with err_o.
module mem_resp_sram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH     = 4096,
    parameter int GNT_WAIT  = 0,
    parameter int RESP_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (GNT_WAIT > RESP_WAIT) ? GNT_WAIT : RESP_WAIT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] GNT_LOAD  = CW'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
    localparam logic [CW-1:0] RESP_LOAD = CW'((RESP_WAIT > 0) ? RESP_WAIT - 1 : 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     idx_i;
    logic              gnt, oor;
    logic              ram_en, ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign idx_i = addr_i[AW+1:2];

`ifdef MEM_RESP_ERR_EN
    logic unused_addr;
    assign oor         = |addr_i[31:AW+2];
    assign unused_addr = ^addr_i[1:0];
`else
    logic unused_addr;
    assign oor         = 1'b0;
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && GNT_WAIT == 0) begin
                    gnt = 1'b1;
                end else if (req_i) begin
                    state_d = WAIT_GNT;
                    cnt_d   = GNT_LOAD;
                end
            end
            WAIT_GNT: begin
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = RESP;
                else cnt_d = cnt_q - 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A grant coinciding with reset must not commit a write
        if (rst) gnt = 1'b0;
        if (gnt) begin
            state_d = (RESP_WAIT == 0) ? RESP : BUSY;
            cnt_d   = RESP_LOAD;
        end
    end

    always_comb begin
        we_d  = we_q;
        err_d = err_q;
        idx_d = idx_q;
        if (gnt) begin
            we_d  = we_i;
            err_d = oor;
            idx_d = idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Read at the grant edge, or again on entry to RESP from the captured index
    assign ram_en   = gnt | (state_q == BUSY && state_d == RESP);
    assign ram_we   = gnt & we_i & ~oor;
    assign ram_addr = gnt ? idx_i : idx_q;

    sram_1rw_be #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (be_i),
        .addr  (ram_addr),
        .wdata (wdata_i),
        .rdata (ram_rdata)
    );

    assign gnt_o    = gnt;
    assign rvalid_o = (state_q == RESP);
    assign err_o    = rvalid_o & err_q;
    assign rdata_o  = (rvalid_o && !we_q && !err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_resp_sram.sv
// Scoreboard bench: dut0 with no wait states, dut1 with GNT_WAIT=2, RESP_WAIT=3.
module tb_mem_resp_sram;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        req    [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        mon_e;
    logic [31:0] mdl [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_resp_sram #(.DEPTH(DEPTH), .GNT_WAIT(0), .RESP_WAIT(0)) dut0 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    mem_resp_sram #(.DEPTH(DEPTH), .GNT_WAIT(2), .RESP_WAIT(3)) dut1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    function automatic logic out_of_range(input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
        return |a[31:AW+2];
`else
        return 1'b0;
`endif
    endfunction

    function automatic void push_exp(input int d, input logic w, input logic [31:0] a,
                                     input logic [3:0] b, input logic [31:0] wd);
        exp_t e;
        int   i;
        logic bad;
        i       = int'(a[AW+1:2]);
        bad     = out_of_range(a);
        e.err   = bad;
        e.rdata = '0;
        if (w) begin
            if (!bad) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[d][i][8*k +: 8] = wd[8*k +: 8];
            end
        end else if (!bad) begin
            e.rdata = mdl[d][i];
        end
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    // Response scoreboard: every rvalid pops one expected entry
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                n_tests++;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid dut%0d cyc=%0d got rdata=%h err=%b required no response",
                             d, cyc, rdata[d], err[d]);
                end else begin
                    if (d == 0) mon_e = q0.pop_front();
                    else mon_e = q1.pop_front();
                    if (rdata[d] !== mon_e.rdata || err[d] !== mon_e.err) begin
                        n_fail++;
                        $display("FAIL response dut%0d cyc=%0d got rdata=%h err=%b required rdata=%h err=%b",
                                 d, cyc, rdata[d], err[d], mon_e.rdata, mon_e.err);
                    end
                end
            end else begin
                n_tests++;
                if (rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs dut%0d cyc=%0d got rdata=%h err=%b rvalid=%b required 0",
                             d, cyc, rdata[d], err[d], rvalid[d]);
                end
            end
        end
    end

    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, output int sc, output int gc, output int rc);
        push_exp(d, w, a, b, wd);
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        sc = cyc; gc = -1; rc = -1;
        for (int n = 0; n < 20 && gc < 0; n++) begin
            @(negedge clk);
            if (gnt[d] === 1'b1) gc = cyc;
            @(posedge clk); #1;
        end
        req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; be[d] = ~b; wdata[d] = ~wd;
        if (gc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL grant_timeout dut%0d addr=%h got no gnt required gnt", d, a);
            if (d == 0) void'(q0.pop_back());
            else void'(q1.pop_back());
            return;
        end
        for (int n = 0; n < 20 && rc < 0; n++) begin
            @(negedge clk);
            if (rvalid[d] === 1'b1) rc = cyc;
        end
        @(posedge clk); #1;
        if (rc < 0) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_timeout dut%0d addr=%h got no rvalid required rvalid", d, a);
            if (d == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic test_reset;
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({gnt[d], rvalid[d], err[d], rdata[d]} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got gnt=%b rvalid=%b err=%b rdata=%h required all 0",
                         d, gnt[d], rvalid[d], err[d], rdata[d]);
            end
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    task automatic test_write_read;
        int sc, gc, rc;
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, sc, gc, rc);
        n_tests++;
        if (gc !== sc || rc !== gc + 1) begin
            n_fail++;
            $display("FAIL wr_timing got req=%0d gnt=%0d rvalid=%0d required gnt=req rvalid=gnt+1", sc, gc, rc);
        end
        txn(0, 1'b0, 32'h10, 4'hF, 32'h0, sc, gc, rc);
        n_tests++;
        if (gc !== sc || rc !== gc + 1) begin
            n_fail++;
            $display("FAIL rd_timing got req=%0d gnt=%0d rvalid=%0d required gnt=req rvalid=gnt+1", sc, gc, rc);
        end
    endtask

    task automatic test_byte_lanes;
        int sc, gc, rc;
        txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, sc, gc, rc);
        txn(0, 1'b1, 32'h21, 4'h2, 32'h0000AA00, sc, gc, rc);
        txn(0, 1'b0, 32'h20, 4'h0, 32'h0, sc, gc, rc);
        txn(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, sc, gc, rc);
        txn(0, 1'b0, 32'h23, 4'h0, 32'h0, sc, gc, rc);
        n_tests++;
        if (mdl[0][8] !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL lane_model got %h required 1122aa44", mdl[0][8]);
        end
    endtask

    task automatic test_back_to_back;
        int sc, g1, g2, rc;
        txn(0, 1'b1, 32'h30, 4'hF, 32'hA5A5A5A5, sc, g1, rc);
        txn(0, 1'b0, 32'h30, 4'hF, 32'h0, sc, g2, rc);
        n_tests++;
        if (g2 !== g1 + 2) begin
            n_fail++;
            $display("FAIL b2b_fast got grant gap=%0d required 2", g2 - g1);
        end
        txn(1, 1'b1, 32'h34, 4'hF, 32'h5A5A0F0F, sc, g1, rc);
        txn(1, 1'b0, 32'h34, 4'hF, 32'h0, sc, g2, rc);
        n_tests++;
        if (g2 !== g1 + 7) begin
            n_fail++;
            $display("FAIL b2b_wait got grant gap=%0d required 7", g2 - g1);
        end
    endtask

    task automatic test_wait_states;
        int sc, gc, rc;
        txn(1, 1'b1, 32'h10, 4'hF, 32'h89ABCDEF, sc, gc, rc);
        n_tests++;
        if (gc !== sc + 2 || rc !== gc + 4) begin
            n_fail++;
            $display("FAIL wait_wr got req=%0d gnt=%0d rvalid=%0d required gnt=req+2 rvalid=gnt+4", sc, gc, rc);
        end
        txn(1, 1'b0, 32'h10, 4'hF, 32'h0, sc, gc, rc);
        n_tests++;
        if (gc !== sc + 2 || rc !== gc + 4) begin
            n_fail++;
            $display("FAIL wait_rd got req=%0d gnt=%0d rvalid=%0d required gnt=req+2 rvalid=gnt+4", sc, gc, rc);
        end
    endtask

    task automatic test_withdraw;
        int sc, gc, rc, seen;
        seen = 0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10;
        @(negedge clk);
        if (gnt[1] === 1'b1) seen++;
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (gnt[1] === 1'b1 || rvalid[1] === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL withdraw got %0d gnt/rvalid cycles required 0", seen);
        end
        @(posedge clk); #1;
        txn(1, 1'b1, 32'h44, 4'hF, 32'h0BADF00D, sc, gc, rc);
        n_tests++;
        if (gc !== sc + 2) begin
            n_fail++;
            $display("FAIL withdraw_regrant got gnt delay=%0d required 2", gc - sc);
        end
    endtask

    task automatic test_reset_mid;
        int sc, gc, rc, seen;
        txn(1, 1'b1, 32'h40, 4'hF, 32'h55AA55AA, sc, gc, rc);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; be[1] = 4'hF;
        gc = -1;
        for (int n = 0; n < 10 && gc < 0; n++) begin
            @(negedge clk);
            if (gnt[1] === 1'b1) gc = cyc;
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        n_tests++;
        if (gc < 0) begin
            n_fail++;
            $display("FAIL rstmid_grant got no gnt required gnt");
        end
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({gnt[1], rvalid[1], err[1], rdata[1]} !== 35'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got gnt=%b rvalid=%b err=%b rdata=%h required all 0",
                     gnt[1], rvalid[1], err[1], rdata[1]);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid[1] === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_rvalid got %0d responses required 0", seen);
        end
        @(posedge clk); #1;
        txn(1, 1'b0, 32'h40, 4'hF, 32'h0, sc, gc, rc);
    endtask

    task automatic test_reset_write;
        int sc, gc, rc;
        txn(0, 1'b1, 32'h80, 4'hF, 32'h12345678, sc, gc, rc);
        rst[0] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; be[0] = 4'hF; wdata[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst[0] = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
        txn(0, 1'b0, 32'h80, 4'hF, 32'h0, sc, gc, rc);
    endtask

    task automatic test_range;
        int sc, gc, rc;
        txn(0, 1'b1, 32'h0, 4'hF, 32'h01020304, sc, gc, rc);
        txn(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, sc, gc, rc);
        txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, sc, gc, rc);
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, sc, gc, rc);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0;
            addr[d] = '0; be[d] = '0; wdata[d] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_wait_states();
        test_withdraw();
        test_reset_mid();
        test_reset_write();
        test_range();
        repeat (4) @(negedge clk);
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain got pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
